// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter serialising WRITE/SET/CLR ops from N_REQ agents onto one register.
// Optional feature macro ARB_LOCK_EN: a granted requester holding lock keeps the grant for back-to-back ops.
module shared_reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] data,
  input  logic [N_REQ-1:0]       lock,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       q,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] win_reg, win_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [N_REQ-1:0] done_reg, done_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             rel_grant;

  logic [1:0]       op_arr   [N_REQ];
  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [N_REQ-1:0] req_rot;
  logic [PTR_W-1:0] offset;
  logic [PTR_W-1:0] winner;

  // Indices are at most 2*N_REQ-2, so one conditional subtract wraps them.
  function automatic logic [PTR_W-1:0] wrap(input logic [SUM_W-1:0] s);
    if (s >= SUM_W'(N_REQ))
      wrap = PTR_W'(s - SUM_W'(N_REQ));
    else
      wrap = PTR_W'(s);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign op_arr[gi]   = op[2*gi +: 2];
      assign data_arr[gi] = data[WIDTH*gi +: WIDTH];
      // req_rot[0] is the requester at the pointer, i.e. the highest priority.
      assign req_rot[gi]  = req[wrap(SUM_W'(ptr_reg) + SUM_W'(gi))];
    end
  endgenerate

  always_comb begin
    offset = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = PTR_W'(k);
    end
    winner = wrap(SUM_W'(ptr_reg) + SUM_W'(offset));
  end

`ifndef ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    win_next   = win_reg;
    gnt_next   = gnt_reg;
    done_next  = '0;
    q_next     = q_reg;
    rel_grant  = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (|req) begin
          win_next         = winner;
          gnt_next[winner] = 1'b1;
          state_next       = ACCESS;
        end
      end
      ACCESS: begin
        rel_grant = 1'b1;
        if (req[win_reg]) begin
          case (op_arr[win_reg])
            OP_WRITE: q_next = data_arr[win_reg];
            OP_SET:   q_next = q_reg | data_arr[win_reg];
            OP_CLR:   q_next = q_reg & ~data_arr[win_reg];
            default:  q_next = q_reg;
          endcase
          done_next[win_reg] = 1'b1;
`ifdef ARB_LOCK_EN
          if (lock[win_reg]) rel_grant = 1'b0;
`endif
        end
        // The last winner becomes lowest priority whether it completed or abandoned.
        if (rel_grant) begin
          ptr_next   = wrap(SUM_W'(win_reg) + SUM_W'(1));
          gnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      q_reg     <= q_next;
    end
  end

  assign gnt  = gnt_reg;
  assign done = done_reg;
  assign q    = q_reg;
  assign busy = (state_reg == ACCESS);

endmodule
